// File: rtl/rh_pair_dispatcher.sv
// rh_pair_dispatcher: buffers the generator's two instruction lanes in
// independent FIFOs, re-aligns them into slot pairs for the controller's
// two-slot port and counts the ACT commands that are actually issued.

`ifndef DDR_INSTR
`define DDR_INSTR  4'b1000
`endif
`ifndef CS_OFFSET
`define CS_OFFSET  26
`endif
`ifndef RAS_OFFSET
`define RAS_OFFSET 25
`endif
`ifndef CAS_OFFSET
`define CAS_OFFSET 24
`endif
`ifndef WE_OFFSET
`define WE_OFFSET  23
`endif

// One lane FIFO. Registered count plus wrapping pointers. The head is forced
// to zero while the lane is empty, so the storage never needs a reset.
module rh_lane_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = empty ? '0 : mem[rptr];

  // Pointer and count update; flush and rst discard any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage write. A write that coincides with flush lands in a slot that is
  // already considered free, so it is harmless.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end
endmodule

module rh_pair_dispatcher #(
  parameter int DEPTH     = 8,
  parameter int INSTR_W   = 32,
  parameter int ACT_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [INSTR_W-1:0]   instr0_in,
  input  logic                 en0,
  input  logic [INSTR_W-1:0]   instr1_in,
  input  logic                 en1,
  output logic                 ready0,
  output logic                 ready1,
  output logic                 pair_valid,
  output logic [INSTR_W-1:0]   pair_instr0,
  output logic [INSTR_W-1:0]   pair_instr1,
  input  logic                 pair_ready,
  output logic [ACT_CNT_W-1:0] act_count,
  output logic                 busy,
  output logic                 ovf_err
);
  localparam int NL = 2;

  logic [NL-1:0]              en, push, full, empty, act_slot;
  logic [NL-1:0][INSTR_W-1:0] din, head;
  logic                       pop;

  assign en  = {en1, en0};
  assign din = {instr1_in, instr0_in};

  // Ready comes only from registered lane state, never from en or pair_ready.
  assign push = en & ~full;
  assign pop  = pair_valid & pair_ready;

  genvar l;
  generate
    for (l = 0; l < NL; l++) begin : g_lane
      rh_lane_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push[l]),
        .pop   (pop),
        .din   (din[l]),
        .head  (head[l]),
        .full  (full[l]),
        .empty (empty[l])
      );
      // ACT: DDR command with CS low, RAS low, CAS high, WE high.
      assign act_slot[l] = (head[l][31:28] == `DDR_INSTR) &
                           ~head[l][`CS_OFFSET] & ~head[l][`RAS_OFFSET] &
                            head[l][`CAS_OFFSET] & head[l][`WE_OFFSET];
    end
  endgenerate

  assign ready0      = ~full[0];
  assign ready1      = ~full[1];
  assign pair_valid  = ~empty[0] & ~empty[1];
  assign pair_instr0 = head[0];
  assign pair_instr1 = head[1];
  assign busy        = ~empty[0] | ~empty[1];

  logic [1:0]           n_act;
  logic [ACT_CNT_W:0]   act_sum;
  assign n_act   = {1'b0, act_slot[0]} + {1'b0, act_slot[1]};
  assign act_sum = {1'b0, act_count} + (ACT_CNT_W+1)'(n_act);

  // Saturating ACT counter, advanced only by pops that flush does not cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_count <= '0;
    end else if (pop && !flush) begin
      act_count <= act_sum[ACT_CNT_W] ? '1 : act_sum[ACT_CNT_W-1:0];
    end
  end

  // Sticky overflow flag: a push was attempted into a full lane.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_err <= 1'b0;
    else if (!flush && |(en & full))
      ovf_err <= 1'b1;
  end
endmodule

// File: tb/tb_rh_pair_dispatcher.sv
// Directed bench for rh_pair_dispatcher: a vector table for the single-cycle
// behaviour plus hand-written fill, overflow, wrap, flush and reset sequences.
module tb_rh_pair_dispatcher;
  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CW    = 32;

  logic          clk = 0, rst = 1, flush = 0, en0 = 0, en1 = 0, pair_ready = 0;
  logic [W-1:0]  instr0_in = '0, instr1_in = '0;
  logic          ready0, ready1, pair_valid, busy, ovf_err;
  logic [W-1:0]  pair_instr0, pair_instr1;
  logic [CW-1:0] act_count;

  int checks = 0, errors = 0;

  rh_pair_dispatcher #(.DEPTH(DEPTH), .INSTR_W(W), .ACT_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr0_in(instr0_in), .en0(en0), .instr1_in(instr1_in), .en1(en1),
    .ready0(ready0), .ready1(ready1), .pair_valid(pair_valid),
    .pair_instr0(pair_instr0), .pair_instr1(pair_instr1), .pair_ready(pair_ready),
    .act_count(act_count), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  // softMC-style encodings built independently of the RTL macros
  function automatic logic [W-1:0] mk_act(input logic [15:0] row);
    logic [W-1:0] i;
    i = '0; i[31:28] = 4'h8; i[27] = 1'b1;
    i[26] = 1'b0; i[25] = 1'b0; i[24] = 1'b1; i[23] = 1'b1; i[15:0] = row;
    return i;
  endfunction
  function automatic logic [W-1:0] mk_rd(input logic [15:0] col);
    logic [W-1:0] i;
    i = '0; i[31:28] = 4'h8; i[27] = 1'b1;
    i[26] = 1'b0; i[25] = 1'b1; i[24] = 1'b0; i[23] = 1'b1; i[15:0] = col;
    return i;
  endfunction
  function automatic logic [W-1:0] mk_wait(input logic [15:0] cyc);
    logic [W-1:0] i;
    i = '0; i[31:28] = 4'h4; i[15:0] = cyc;
    return i;
  endfunction
  function automatic logic [W-1:0] mk_busdir(input logic d);
    logic [W-1:0] i;
    i = '0; i[31:28] = 4'h1; i[0] = d;
    return i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, settle.
  task automatic step(input logic f, input logic e0, input logic [W-1:0] i0,
                      input logic e1, input logic [W-1:0] i1, input logic pr);
    @(negedge clk);
    flush = f; en0 = e0; instr0_in = i0; en1 = e1; instr1_in = i1; pair_ready = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic r0, input logic r1, input logic pv,
                         input logic [W-1:0] p0, input logic [W-1:0] p1, input logic b,
                         input logic o, input logic [CW-1:0] a);
    chk({tag, ".ready0"}, 64'(ready0), 64'(r0));
    chk({tag, ".ready1"}, 64'(ready1), 64'(r1));
    chk({tag, ".pair_valid"}, 64'(pair_valid), 64'(pv));
    chk({tag, ".pair_instr0"}, 64'(pair_instr0), 64'(p0));
    chk({tag, ".pair_instr1"}, 64'(pair_instr1), 64'(p1));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".ovf_err"}, 64'(ovf_err), 64'(o));
    chk({tag, ".act_count"}, 64'(act_count), 64'(a));
  endtask

  typedef struct {
    logic f, e0, e1, pr;
    logic [W-1:0] i0, i1;
    logic r0, r1, pv, b, o;
    logic [W-1:0] p0, p1;
    logic [CW-1:0] a;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [W-1:0] A, B, C, X, Y, Z, z;
    z = '0;
    A = mk_act(16'd1); B = mk_rd(16'd3); C = mk_wait(16'd7);
    X = mk_wait(16'd1); Y = mk_act(16'd2); Z = mk_busdir(1'b1);
    //          f  e0 e1 pr  i0            i1            r0 r1 pv b  o  p0            p1           act
    vt[0] = '{1'b0,1'b0,1'b0,1'b1, z, z,                          1,1,0,0,0, z, z, 0};
    vt[1] = '{1'b0,1'b1,1'b1,1'b1, mk_act(16'd5), mk_wait(16'd4), 1,1,1,1,0, mk_act(16'd5), mk_wait(16'd4), 0};
    vt[2] = '{1'b0,1'b0,1'b0,1'b1, z, z,                          1,1,0,0,0, z, z, 1};
    vt[3] = '{1'b0,1'b1,1'b0,1'b1, A, z,                          1,1,0,1,0, A, z, 1};
    vt[4] = '{1'b0,1'b1,1'b0,1'b1, B, z,                          1,1,0,1,0, A, z, 1};
    vt[5] = '{1'b0,1'b1,1'b0,1'b1, C, z,                          1,1,0,1,0, A, z, 1};
    vt[6] = '{1'b0,1'b0,1'b1,1'b1, z, X,                          1,1,1,1,0, A, X, 1};
    vt[7] = '{1'b0,1'b0,1'b1,1'b1, z, Y,                          1,1,1,1,0, B, Y, 2};
    vt[8] = '{1'b0,1'b0,1'b1,1'b1, z, Z,                          1,1,1,1,0, C, Z, 3};
    vt[9] = '{1'b0,1'b0,1'b0,1'b1, z, z,                          1,1,0,0,0, z, z, 3};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    chk_all("reset", 1, 1, 0, z, z, 0, 0, 0);

    for (int k = 0; k < 10; k++) begin
      step(vt[k].f, vt[k].e0, vt[k].i0, vt[k].e1, vt[k].i1, vt[k].pr);
      chk_all($sformatf("vec%0d", k), vt[k].r0, vt[k].r1, vt[k].pv,
              vt[k].p0, vt[k].p1, vt[k].b, vt[k].o, vt[k].a);
    end

    // Fill lane 0 with the port stalled, then overflow it.
    for (int k = 0; k < DEPTH; k++) step(0, 1, mk_wait(16'(k + 10)), 0, z, 0);
    chk("fill.ready0", 64'(ready0), 64'd0);
    chk("fill.ready1", 64'(ready1), 64'd1);
    chk("fill.pair_valid", 64'(pair_valid), 64'd0);
    chk("fill.ovf_before", 64'(ovf_err), 64'd0);
    step(0, 1, mk_wait(16'hdead), 0, z, 0);
    chk("ovf.ovf_err", 64'(ovf_err), 64'd1);
    chk("ovf.ready0", 64'(ready0), 64'd0);
    chk("ovf.head0", 64'(pair_instr0), 64'(mk_wait(16'd10)));

    // Fill lane 1, then pop while pushing into both full lanes.
    for (int k = 0; k < DEPTH; k++) step(0, 0, z, 1, mk_act(16'(k + 100)), 0);
    chk("full.ready1", 64'(ready1), 64'd0);
    chk("full.pair_valid", 64'(pair_valid), 64'd1);
    step(0, 1, mk_rd(16'h77), 1, mk_rd(16'h88), 1);
    chk("fullpop.ready0", 64'(ready0), 64'd1);
    chk("fullpop.ready1", 64'(ready1), 64'd1);
    chk("fullpop.head0", 64'(pair_instr0), 64'(mk_wait(16'd11)));
    chk("fullpop.head1", 64'(pair_instr1), 64'(mk_act(16'd101)));
    chk("fullpop.act", 64'(act_count), 64'd4);
    // Drain: the refused pushes must not show up.
    for (int k = 1; k < DEPTH; k++) begin
      chk($sformatf("drain%0d.head0", k), 64'(pair_instr0), 64'(mk_wait(16'(k + 10))));
      chk($sformatf("drain%0d.head1", k), 64'(pair_instr1), 64'(mk_act(16'(k + 100))));
      step(0, 0, z, 0, z, 1);
    end
    chk("drain.busy", 64'(busy), 64'd0);
    chk("drain.act", 64'(act_count), 64'd11);
    chk("drain.ovf_sticky", 64'(ovf_err), 64'd1);

    // Clean restart, then stream 20 ACT pairs back to back so pointers wrap.
    @(negedge clk); rst = 1; @(posedge clk); #1; @(negedge clk); rst = 0; #1;
    chk_all("rst2", 1, 1, 0, z, z, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, mk_act(16'(k)), 1, mk_act(16'(k + 1000)), 1);
      chk($sformatf("stream%0d.head0", k), 64'(pair_instr0), 64'(mk_act(16'(k))));
      chk($sformatf("stream%0d.head1", k), 64'(pair_instr1), 64'(mk_act(16'(k + 1000))));
      chk($sformatf("stream%0d.pv", k), 64'(pair_valid), 64'd1);
    end
    step(0, 0, z, 0, z, 1);
    chk("stream.busy", 64'(busy), 64'd0);
    chk("stream.act", 64'(act_count), 64'd40);

    // Four queued pairs plus an overflowed lane 1, then flush with a push and pop.
    for (int k = 0; k < 4; k++) step(0, 1, mk_act(16'(k)), 1, mk_act(16'(k)), 0);
    for (int k = 0; k < 4; k++) step(0, 0, z, 1, mk_wait(16'(k)), 0);
    step(0, 0, z, 1, mk_wait(16'h99), 0);
    chk("pre_flush.ovf", 64'(ovf_err), 64'd1);
    step(1, 1, mk_act(16'h5), 1, mk_act(16'h6), 1);
    chk_all("flush", 1, 1, 0, z, z, 0, 1, 40);
    step(0, 0, z, 0, z, 1);
    chk("post_flush.busy", 64'(busy), 64'd0);
    chk("post_flush.act", 64'(act_count), 64'd40);

    // Reset with a pair pending.
    step(0, 1, mk_act(16'h42), 1, mk_act(16'h43), 0);
    chk("pending.pv", 64'(pair_valid), 64'd1);
    @(negedge clk); rst = 1; en0 = 0; en1 = 0; pair_ready = 1;
    @(posedge clk); #1;
    chk_all("mid_rst", 1, 1, 0, z, z, 0, 0, 0);
    @(negedge clk); rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
